lcd_frame_scheduler: RTL

// - Owns the single 9-bit packet path into the ST7789V3 serdes FIFO ({dc, byte}; dc=0 command, dc=1 data).
// - Sequences two phases. Phase 1 passes the init/config decoder stream through. Phase 2 emits the

---
 rtl/lcd_frame_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lcd_frame_scheduler.sv
// Frame scheduler for the ST7789V3 serdes FIFO: init pass-through, window header, pixel byte stream.
// Optional inter-frame idle gap compiled in with `define LCD_SCHED_FRAME_GAP_EN.
module lcd_frame_scheduler #(
  parameter int PACKET_WIDTH = 9,
  parameter int DISP_W       = 135,
  parameter int DISP_H       = 240,
  parameter int X_OFF        = 52,
  parameter int Y_OFF        = 40,
  parameter int FRAME_GAP    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    run,
  output logic                    cfg_en,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [PACKET_WIDTH-1:0] cfg_data,
  input  logic                    cfg_done,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [15:0]             pix_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PACKET_WIDTH-1:0] out_data,
  output logic                    busy,
  output logic                    frame_done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_HDR    = 3'd2;
  localparam logic [2:0] ST_PIX_HI = 3'd3;
  localparam logic [2:0] ST_PIX_LO = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;

  localparam int              NPIX     = DISP_W * DISP_H;
  localparam int              CNT_W    = $clog2(NPIX + 1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);

  localparam logic [15:0] X0 = 16'(X_OFF);
  localparam logic [15:0] X1 = 16'(X_OFF + DISP_W - 1);
  localparam logic [15:0] Y0 = 16'(Y_OFF);
  localparam logic [15:0] Y1 = 16'(Y_OFF + DISP_H - 1);

  logic [2:0]       state;
  logic [3:0]       hdr_idx;
  logic [CNT_W-1:0] pix_cnt;
  logic [7:0]       lo_byte;
  logic             done_seen;
  logic [8:0]       hdr_pkt;
  logic [2:0]       frame_next;

`ifdef LCD_SCHED_FRAME_GAP_EN
  localparam int GAP_W = $clog2(FRAME_GAP + 1);
  logic [GAP_W-1:0] gap_cnt;
  assign frame_next = ST_GAP;
`else
  assign frame_next = ST_HDR;
`endif

  // Window header: CASET x0..x1, RASET y0..y1, then RAMWR.
  always_comb begin
    case (hdr_idx)
      4'd0:    hdr_pkt = {1'b0, 8'h2A};
      4'd1:    hdr_pkt = {1'b1, X0[15:8]};
      4'd2:    hdr_pkt = {1'b1, X0[7:0]};
      4'd3:    hdr_pkt = {1'b1, X1[15:8]};
      4'd4:    hdr_pkt = {1'b1, X1[7:0]};
      4'd5:    hdr_pkt = {1'b0, 8'h2B};
      4'd6:    hdr_pkt = {1'b1, Y0[15:8]};
      4'd7:    hdr_pkt = {1'b1, Y0[7:0]};
      4'd8:    hdr_pkt = {1'b1, Y1[15:8]};
      4'd9:    hdr_pkt = {1'b1, Y1[7:0]};
      default: hdr_pkt = {1'b0, 8'h2C};
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no state leaves one unassigned (no latch).
    out_valid = 1'b0;
    out_data  = '0;
    cfg_ready = 1'b0;
    pix_ready = 1'b0;
    case (state)
      ST_INIT: begin
        out_valid = cfg_valid;
        out_data  = cfg_data;
        cfg_ready = out_ready;
      end
      ST_HDR: begin
        out_valid = 1'b1;
        out_data  = PACKET_WIDTH'(hdr_pkt);
      end
      ST_PIX_HI: begin
        out_valid = pix_valid;
        out_data  = PACKET_WIDTH'({1'b1, pix_data[15:8]});
      end
      ST_PIX_LO: begin
        out_valid = 1'b1;
        out_data  = PACKET_WIDTH'({1'b1, lo_byte});
        pix_ready = out_ready;
      end
      default: ;
    endcase
  end

  assign cfg_en = (state == ST_INIT);
  assign busy   = (state != ST_IDLE);

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      hdr_idx    <= '0;
      pix_cnt    <= '0;
      lo_byte    <= '0;
      done_seen  <= 1'b0;
      frame_done <= 1'b0;
`ifdef LCD_SCHED_FRAME_GAP_EN
      gap_cnt    <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: if (start) state <= ST_INIT;
        ST_INIT: begin
          // A held packet must drain before the header may take over the output.
          if ((cfg_done || done_seen) && !(cfg_valid && !out_ready)) begin
            state     <= ST_HDR;
            hdr_idx   <= '0;
            done_seen <= 1'b0;
          end else if (cfg_done) begin
            done_seen <= 1'b1;
          end
        end
        ST_HDR: if (out_ready) begin
          if (hdr_idx == 4'd10) begin
            hdr_idx <= '0;
            state   <= ST_PIX_HI;
          end else begin
            hdr_idx <= hdr_idx + 4'd1;
          end
        end
        ST_PIX_HI: if (pix_valid && out_ready) begin
          lo_byte <= pix_data[7:0];
          state   <= ST_PIX_LO;
        end
        ST_PIX_LO: if (out_ready) begin
          if (pix_cnt == LAST_PIX) begin
            pix_cnt    <= '0;
            frame_done <= 1'b1;
            state      <= run ? frame_next : ST_IDLE;
          end else begin
            pix_cnt <= pix_cnt + CNT_W'(1);
            state   <= ST_PIX_HI;
          end
        end
`ifdef LCD_SCHED_FRAME_GAP_EN
        ST_GAP: begin
          if (!run) begin
            gap_cnt <= '0;
            state   <= ST_IDLE;
          end else if (gap_cnt == GAP_W'(FRAME_GAP - 1)) begin
            gap_cnt <= '0;
            state   <= ST_HDR;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
